// File: rtl/instr_encode_loader_if.sv
// Field-bundle stream into the instruction loader: one MIPS instruction's
// fields plus format tag, qualified by in_valid/in_ready.
interface instr_encode_loader_if;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_fmt;
   logic [5:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [4:0]  in_shamt;
   logic [5:0]  in_funct;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        in_last;

   modport master (
      output in_valid, in_fmt, in_op, in_rs, in_rt, in_rd, in_shamt,
             in_funct, in_imm, in_target, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_fmt, in_op, in_rs, in_rt, in_rd, in_shamt,
             in_funct, in_imm, in_target, in_last,
      output in_ready
   );
endinterface

// File: rtl/instr_encode_loader.sv
// Packs R/I/J field bundles into 32-bit MIPS words, buffers them in a small
// FIFO and streams them into instruction memory from BASE_ADDR upward.
module instr_encode_loader #(
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 4,
   parameter int BASE_ADDR  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   instr_encode_loader_if.slave bus,
   output logic                 imem_we,
   output logic [ADDR_W-1:0]    imem_addr,
   output logic [31:0]          imem_wdata,
   output logic [ADDR_W:0]      words_written,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t             state, next_state;
   logic [31:0]        enc_word;
   logic               fmt_ok;
   logic               xfer, push, pop, full;
   logic [CNT_W-1:0]   count;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [31:0]        mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]  wptr;

   // Format-driven packing; fields outside the chosen format are ignored.
   always_comb begin
      enc_word = '0;
      fmt_ok   = 1'b1;
      case (bus.in_fmt)
         2'b00:   enc_word = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd,
                              bus.in_shamt, bus.in_funct};
         2'b01:   enc_word = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_imm};
         2'b10:   enc_word = {bus.in_op, bus.in_target};
         default: fmt_ok   = 1'b0;
      endcase
   end

   assign xfer = bus.in_valid && bus.in_ready;
   assign push = xfer && fmt_ok;
   assign pop  = (count != '0);
   assign full = (count == CNT_W'(FIFO_DEPTH));

   // FIFO control; readiness uses registered occupancy only, so no
   // push-through-pop when full.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= enc_word;
   end

   // Write path: drain one word per cycle; the pointer wraps and flags err.
   always_ff @(posedge clk) begin
      if (rst) begin
         imem_we       <= 1'b0;
         imem_addr     <= BASE;
         imem_wdata    <= '0;
         wptr          <= BASE;
         words_written <= '0;
         err           <= 1'b0;
      end else begin
         imem_we <= pop;
         if (state == IDLE && start) begin
            wptr          <= BASE;
            words_written <= '0;
            err           <= 1'b0;
         end
         if (pop) begin
            imem_addr     <= wptr;
            imem_wdata    <= mem[rd_ptr];
            wptr          <= wptr + ADDR_W'(1);
            words_written <= words_written + (ADDR_W+1)'(1);
            if (wptr == '1) err <= 1'b1;
         end
         if (xfer && !fmt_ok) err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // DRAIN exits once the FIFO is empty; the final pop already registered
   // its write on the edge that emptied it.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = LOAD;
         LOAD:    if (xfer && bus.in_last) next_state = DRAIN;
         DRAIN:   if (count == '0) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         LOAD: begin
            bus.in_ready = !full;
            busy         = 1'b1;
         end
         DRAIN:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed and random sessions driven into two loaders (10-bit and 2-bit
// address) in lockstep, checked cycle by cycle against a session-level model.
module tb_instr_encode_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   always #5 clk = ~clk;

   instr_encode_loader_if ia();
   instr_encode_loader_if ib();

   assign ib.in_valid  = ia.in_valid;
   assign ib.in_fmt    = ia.in_fmt;
   assign ib.in_op     = ia.in_op;
   assign ib.in_rs     = ia.in_rs;
   assign ib.in_rt     = ia.in_rt;
   assign ib.in_rd     = ia.in_rd;
   assign ib.in_shamt  = ia.in_shamt;
   assign ib.in_funct  = ia.in_funct;
   assign ib.in_imm    = ia.in_imm;
   assign ib.in_target = ia.in_target;
   assign ib.in_last   = ia.in_last;

   logic        we_a, busy_a, done_a, err_a;
   logic [9:0]  addr_a;
   logic [31:0] wd_a;
   logic [10:0] ww_a;
   logic        we_b, busy_b, done_b, err_b;
   logic [1:0]  addr_b;
   logic [31:0] wd_b;
   logic [2:0]  ww_b;

   instr_encode_loader #(.ADDR_W(10), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut_a (
      .clk(clk), .rst(rst), .start(start), .bus(ia),
      .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
      .words_written(ww_a), .busy(busy_a), .done(done_a), .err(err_a));

   instr_encode_loader #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut_b (
      .clk(clk), .rst(rst), .start(start), .bus(ib),
      .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
      .words_written(ww_b), .busy(busy_b), .done(done_b), .err(err_b));

   int checks = 0;
   int failures = 0;

   // Model: session phase 0 idle, 1 loading, 2 draining, 3 done.
   int          ms = 0;
   bit          d1 = 0, d2 = 0;
   logic [31:0] q1 = '0, q2 = '0;
   int          widx = 0;
   bit          erra_m = 0, errb_m = 0;
   int          cyc = 0;
   bit          acc_flag = 0;
   int          acc_cyc = 0;
   int          done_cyc = -1;
   int          last_wait = 0;
   logic [31:0] cap_data[$];
   int          cap_cyc[$];
   int          cap_addr_b[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_ref();
      logic [31:0] w;
      case (ia.in_fmt)
         2'd0: w = (32'(ia.in_op) << 26) | (32'(ia.in_rs) << 21) | (32'(ia.in_rt) << 16)
                 | (32'(ia.in_rd) << 11) | (32'(ia.in_shamt) << 6) | 32'(ia.in_funct);
         2'd1: w = (32'(ia.in_op) << 26) | (32'(ia.in_rs) << 21) | (32'(ia.in_rt) << 16)
                 | 32'(ia.in_imm);
         2'd2: w = (32'(ia.in_op) << 26) | 32'(ia.in_target);
         default: w = '0;
      endcase
      return w;
   endfunction

   task automatic monitor();
      bit exp_rdy, exp_busy, exp_done, acc, fifo_ne;
      cyc++;
      exp_rdy  = (ms == 1);
      exp_busy = (ms == 1) || (ms == 2);
      exp_done = (ms == 3);
      chk("in_ready_a", ia.in_ready, exp_rdy);
      chk("in_ready_b", ib.in_ready, exp_rdy);
      chk("busy_a", busy_a, exp_busy);
      chk("busy_b", busy_b, exp_busy);
      chk("done_a", done_a, exp_done);
      chk("done_b", done_b, exp_done);
      chk("we_a", we_a, d2);
      chk("we_b", we_b, d2);
      if (d2) begin
         if (widx % 4 == 3) errb_m = 1;
         chk("addr_a", addr_a, widx % 1024);
         chk("addr_b", addr_b, widx % 4);
         chk("wdata_a", wd_a, q2);
         chk("wdata_b", wd_b, q2);
         widx++;
      end
      if (we_a) begin
         cap_data.push_back(wd_a);
         cap_cyc.push_back(cyc);
      end
      if (we_b) cap_addr_b.push_back(int'(addr_b));
      if (done_a) done_cyc = cyc;
      chk("words_a", ww_a, widx % 2048);
      chk("words_b", ww_b, widx % 8);
      chk("err_a", err_a, erra_m);
      chk("err_b", err_b, errb_m);
      // Advance the model across the coming edge.
      acc      = ia.in_valid && exp_rdy && !rst;
      acc_flag = acc;
      if (acc) acc_cyc = cyc;
      fifo_ne  = d1;
      d2 = d1 && !rst;
      q2 = q1;
      d1 = acc && (ia.in_fmt != 2'd3);
      q1 = enc_ref();
      if (acc && ia.in_fmt == 2'd3) begin
         erra_m = 1;
         errb_m = 1;
      end
      if (rst) begin
         ms = 0; widx = 0; erra_m = 0; errb_m = 0; d1 = 0;
      end else begin
         case (ms)
            0: if (start) begin ms = 1; widx = 0; erra_m = 0; errb_m = 0; end
            1: if (acc && ia.in_last) ms = 2;
            2: if (!fifo_ne) ms = 3;
            default: ms = 0;
         endcase
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt,
                       input logic last);
      int n;
      bit got_it;
      ia.in_fmt = f; ia.in_op = op; ia.in_rs = rs; ia.in_rt = rt; ia.in_rd = rd;
      ia.in_shamt = sh; ia.in_funct = fn; ia.in_imm = imm; ia.in_target = tgt;
      ia.in_last = last; ia.in_valid = 1'b1;
      n = 0;
      got_it = 0;
      while (n < 20 && !got_it) begin
         tick();
         if (acc_flag) got_it = 1;
         else n++;
      end
      ia.in_valid = 1'b0;
      last_wait = n;
      chk("send_timeout", got_it, 1);
   endtask

   task automatic send_rand(input logic last, input bit allow_bad);
      logic [1:0] f;
      f = 2'($urandom_range(0, 2));
      if (allow_bad && $urandom_range(0, 5) == 0) f = 2'd3;
      send(f, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           6'($urandom), 16'($urandom), 26'($urandom), last);
   endtask

   task automatic begin_session();
      start = 1'b1;
      tick();
      start = 1'b0;
      cap_data.delete();
      cap_cyc.delete();
      cap_addr_b.delete();
      done_cyc = -1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (ms != 0 && n < 50) begin
         tick();
         n++;
      end
      chk("session_end", ms, 0);
   endtask

   initial begin
      int stalls;
      ia.in_valid = 0; ia.in_fmt = 0; ia.in_op = 0; ia.in_rs = 0; ia.in_rt = 0;
      ia.in_rd = 0; ia.in_shamt = 0; ia.in_funct = 0; ia.in_imm = 0;
      ia.in_target = 0; ia.in_last = 0;
      repeat (2) @(posedge clk);
      #1;
      tick();
      chk("rst_addr_a", addr_a, 0);
      chk("rst_wdata_a", wd_a, 0);
      rst = 1'b0;
      tick();

      // Single R-type session.
      begin_session();
      send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'hffff, 26'h3ffffff, 1'b1);
      wait_idle();
      chk("r_count", cap_data.size(), 1);
      if (cap_data.size() == 1) begin
         chk("r_data", cap_data[0], 32'h00221821);
         chk("r_latency", cap_cyc[0] - acc_cyc, 2);
         chk("r_done_gap", done_cyc - cap_cyc[0], 1);
      end
      chk("r_words", ww_a, 1);

      // Back-to-back I, J, lw.
      begin_session();
      send(2'd1, 6'h08, 5'd1, 5'd2, 5'd7, 5'd7, 6'h3f, 16'd5, 26'd0, 1'b0);
      send(2'd2, 6'h02, 5'd9, 5'd9, 5'd9, 5'd9, 6'h3f, 16'h1234, 26'h100, 1'b0);
      send(2'd1, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b1);
      wait_idle();
      chk("b2b_count", cap_data.size(), 3);
      if (cap_data.size() == 3) begin
         chk("b2b_i", cap_data[0], 32'h20220005);
         chk("b2b_j", cap_data[1], 32'h08000100);
         chk("b2b_lw", cap_data[2], 32'h8FA80004);
         chk("b2b_gap", cap_cyc[2] - cap_cyc[0], 2);
      end

      // Six-bundle stream: never stalls, writes back to back.
      begin_session();
      stalls = 0;
      for (int i = 0; i < 6; i++) begin
         send_rand(i == 5, 0);
         stalls += last_wait;
      end
      wait_idle();
      chk("stream_stalls", stalls, 0);
      chk("stream_count", cap_data.size(), 6);
      if (cap_data.size() == 6) chk("stream_gap", cap_cyc[5] - cap_cyc[0], 5);

      // Illegal bundle between two legal ones; err holds until next start.
      begin_session();
      send(2'd0, 6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
      send(2'd3, 6'h3f, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b0);
      send(2'd1, 6'h0d, 5'd3, 5'd3, 5'd0, 5'd0, 6'd0, 16'hbeef, 26'd0, 1'b1);
      wait_idle();
      repeat (3) tick();
      chk("ill_count", cap_data.size(), 2);
      chk("ill_err", err_a, 1);
      // Valid outside LOAD is ignored.
      ia.in_valid = 1'b1;
      repeat (2) tick();
      ia.in_valid = 1'b0;
      chk("idle_valid_writes", cap_data.size(), 2);
      begin_session();
      chk("ill_err_clear", err_a, 0);

      // Five writes: 2-bit address loader wraps.
      for (int i = 0; i < 5; i++) send_rand(i == 4, 0);
      wait_idle();
      chk("wrap_count", cap_addr_b.size(), 5);
      if (cap_addr_b.size() == 5)
         for (int i = 0; i < 5; i++) chk("wrap_addr_b", cap_addr_b[i], i % 4);
      chk("wrap_err_b", err_b, 1);
      chk("wrap_err_a", err_a, 0);

      // Reset in the middle of a load.
      begin_session();
      for (int i = 0; i < 3; i++) send_rand(0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_we", we_a, 0);
      chk("mrst_busy", busy_a, 0);
      chk("mrst_ready", ia.in_ready, 0);
      chk("mrst_done", done_a, 0);
      repeat (3) tick();
      chk("mrst_no_done", done_cyc, -1);
      begin_session();
      send_rand(1, 0);
      wait_idle();
      chk("mrst_restart", cap_data.size(), 1);

      // Random sessions with gaps, illegal bundles and stray starts.
      for (int s = 0; s < 12; s++) begin
         int n;
         begin_session();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            start = ($urandom_range(0, 3) == 0);
            send_rand(i == n - 1, 1);
            start = 1'b0;
         end
         wait_idle();
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
